// File: rtl/vpe_pkg.sv
// Shared definitions for the VPE array and its packet dispatcher.
// Holds the default feature/result widths, a lane-index type sized for the
// largest supported array, and a small population-count helper.
package vpe_pkg;

  localparam int FEA_W_DEF = 128;  // default feature vector width
  localparam int RES_W_DEF = 16;   // default per-packet result width
  localparam int MAX_LANE  = 8;    // largest supported lane count

  // Lane index wide enough for any supported array size.
  typedef logic [$clog2(MAX_LANE)-1:0] lane_idx_t;

  // Number of set bits in a lane mask.
  function automatic int unsigned popcount_lanes(input logic [MAX_LANE-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANE; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/vpe_order_fifo.sv
// Small synchronous FIFO with show-ahead head output.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write an entry (ignored when full and not popping)
//   pop              drop the head entry (ignored when empty)
//   head             current head entry (valid when !empty)
//   empty, full      occupancy flags
module vpe_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage is reset too: head is visible on the output even when
  // the FIFO is empty, so it must come out of reset as a known zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, independent of statement order.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/vpe_pkt_dispatcher.sv
// Shares one packet-feature stream among N_LANE VPE lanes.
// Each accepted feature vector goes to an idle lane chosen round-robin; the
// lane's result is captured into a per-lane slot and results are returned in
// packet arrival order over a valid/ready port.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready/in_fea     feature vector input handshake
//   lane_req                     per-lane fetch request (lane idle, level)
//   lane_fea_valid/lane_fea      one-hot dispatch pulse + broadcast vector
//   lane_res_valid/lane_res      per-lane result pulse + packed results
//   out_valid/out_ready          in-order result handshake
//   out_data/out_lane            result and the lane that produced it
//   busy_lanes                   lanes inflight or holding an unread result
//   err_unexp                    sticky: result pulse from an idle lane
module vpe_pkt_dispatcher
  import vpe_pkg::*;
#(
  parameter  int N_LANE = 4,
  parameter  int FEA_W  = FEA_W_DEF,
  parameter  int RES_W  = RES_W_DEF,
  localparam int LW     = $clog2(N_LANE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FEA_W-1:0]        in_fea,
  input  logic [N_LANE-1:0]       lane_req,
  output logic [N_LANE-1:0]       lane_fea_valid,
  output logic [FEA_W-1:0]        lane_fea,
  input  logic [N_LANE-1:0]       lane_res_valid,
  input  logic [N_LANE*RES_W-1:0] lane_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_data,
  output logic [LW-1:0]           out_lane,
  output logic [LW:0]             busy_lanes,
  output logic                    err_unexp
);

  logic [N_LANE-1:0] inflight;   // dispatched, result not yet returned
  logic [N_LANE-1:0] slot_full;  // result captured, not yet drained
  logic [RES_W-1:0]  slot [N_LANE];
  logic [LW-1:0]     rr_ptr;

  logic [N_LANE-1:0] elig;
  logic [N_LANE-1:0] cap;
  logic [N_LANE-1:0] grant_oh;
  logic [N_LANE-1:0] drain_oh;
  logic [LW-1:0]     grant;
  logic              grant_vld;
  logic              accept;
  logic              drain;
  logic [LW-1:0]     head;
  logic              fifo_empty;
  logic              fifo_full;
  int unsigned       idx;

  assign elig = lane_req & ~inflight & ~slot_full;

  // in_ready is held low during reset so nothing is offered to a lane that
  // is itself being reset.
  assign in_ready = ~rst & (|elig);
  // The order FIFO holds one entry per owned lane and cannot fill while a
  // lane is eligible; the full term only keeps the push unconditionally safe.
  assign accept   = in_valid & in_ready & ~fifo_full;

  // First eligible lane at or after rr_ptr, wrapping past the top lane.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_LANE; k++) begin
      idx = 32'(rr_ptr) + 32'(k);
      if (idx >= 32'(N_LANE)) idx = idx - 32'(N_LANE);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = LW'(idx);
      end
    end
  end

  // A result pulse only counts for a lane that has a packet outstanding.
  assign cap      = lane_res_valid & inflight;
  assign grant_oh = (accept && grant_vld) ? (N_LANE'(1) << grant) : '0;

  assign out_valid = ~fifo_empty & slot_full[head];
  assign out_data  = slot[head];
  assign out_lane  = head;
  assign drain     = out_valid & out_ready;
  assign drain_oh  = drain ? (N_LANE'(1) << head) : '0;

  assign busy_lanes = (LW + 1)'(popcount_lanes(MAX_LANE'(inflight | slot_full)));

  vpe_order_fifo #(
    .DEPTH (N_LANE),
    .WIDTH (LW)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (grant),
    .pop       (drain),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // inflight and slot_full are mutually exclusive per lane, so a grant, a
  // capture and a drain never touch the same lane in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight       <= '0;
      slot_full      <= '0;
      rr_ptr         <= '0;
      lane_fea       <= '0;
      lane_fea_valid <= '0;
      err_unexp      <= 1'b0;
      for (int i = 0; i < N_LANE; i++) slot[i] <= '0;
    end else begin
      lane_fea_valid <= grant_oh;
      if (accept) begin
        lane_fea <= in_fea;
        rr_ptr   <= (grant == LW'(N_LANE - 1)) ? '0 : grant + 1'b1;
      end
      inflight  <= (inflight & ~cap) | grant_oh;
      slot_full <= (slot_full | cap) & ~drain_oh;
      if (|(lane_res_valid & ~inflight)) err_unexp <= 1'b1;
      for (int i = 0; i < N_LANE; i++) begin
        if (cap[i]) slot[i] <= lane_res[i*RES_W +: RES_W];
      end
    end
  end

endmodule

// File: tb/tb_vpe_pkt_dispatcher.sv
// Self-checking bench for vpe_pkt_dispatcher (N_LANE=4).
// Lane behaviour is modelled per lane; a queue-based reference model predicts
// dispatch pulses, occupancy and output order; a monitor process pops the
// expected-result queue whenever the DUT completes an output handshake.
module tb_vpe_pkt_dispatcher;

  localparam int N  = 4;
  localparam int FW = 128;
  localparam int RW = 16;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FW-1:0]   in_fea = '0;
  logic [N-1:0]    lane_req = '0;
  logic [N-1:0]    lane_fea_valid;
  logic [FW-1:0]   lane_fea;
  logic [N-1:0]    lane_res_valid = '0;
  logic [N*RW-1:0] lane_res = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [RW-1:0]   out_data;
  logic [LW-1:0]   out_lane;
  logic [LW:0]     busy_lanes;
  logic            err_unexp;

  always #5 clk = ~clk;

  vpe_pkt_dispatcher #(.N_LANE(N), .FEA_W(FW), .RES_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_fea         (in_fea),
    .lane_req       (lane_req),
    .lane_fea_valid (lane_fea_valid),
    .lane_fea       (lane_fea),
    .lane_res_valid (lane_res_valid),
    .lane_res       (lane_res),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_lane       (out_lane),
    .busy_lanes     (busy_lanes),
    .err_unexp      (err_unexp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [RW-1:0] res;
    int            lane;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: which lanes own a packet, in what order they must drain.
  logic [N-1:0]  m_infl, m_full, m_pulse;
  int            m_rr;
  int            m_order[$];
  logic          m_err;
  logic [FW-1:0] m_fea;
  logic          m_in_ready;

  // Lane behaviour: 0 idle, 1 holding fetch after grant, 2 working.
  int            st[N], hold[N], cnt[N];
  logic [FW-1:0] lfea[N];

  // Stimulus controls.
  int            in_rate = 0, req_pct = 100, or_pct = 100, unexp_lane = -1;
  int            lat_min[N], lat_max[N];
  logic [N-1:0]  req_mask = '1;
  logic [N-1:0]  pulse_seen = '0;
  logic [FW-1:0] src_q[$];

  function automatic logic [RW-1:0] res_of(logic [FW-1:0] f, int lane);
    return f[RW-1:0] + RW'(lane * 257);
  endfunction

  function automatic int popc(logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [FW-1:0] rand_fea();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lat(int lo, int hi);
    for (int i = 0; i < N; i++) begin
      lat_min[i] = lo;
      lat_max[i] = hi;
    end
  endtask

  task automatic model_clear();
    m_infl = '0; m_full = '0; m_pulse = '0; m_rr = 0; m_err = 1'b0;
    m_fea = '0; m_in_ready = 1'b0;
    m_order.delete();
    exp_q.delete();
    src_q.delete();
    pulse_seen = '0;
    for (int i = 0; i < N; i++) begin
      st[i] = 0; hold[i] = 0; cnt[i] = 0; lfea[i] = '0;
    end
  endtask

  task automatic drive_inputs();
    lane_res_valid = '0;
    for (int i = 0; i < N; i++) begin
      lane_req[i] = 1'b0;
      if (st[i] == 0) begin
        lane_req[i] = req_mask[i] && ($urandom_range(0, 99) < req_pct);
      end
      if (st[i] == 1) begin
        if (hold[i] > 0) begin
          lane_req[i] = 1'b1;
          hold[i]--;
        end else st[i] = 2;
      end
      if (st[i] == 2) begin
        if (cnt[i] <= 1) begin
          lane_res_valid[i]    = 1'b1;
          lane_res[i*RW +: RW] = res_of(lfea[i], i);
          st[i] = 0;
        end else cnt[i]--;
      end
    end
    if (unexp_lane >= 0) begin
      lane_res_valid[unexp_lane]    = 1'b1;
      lane_res[unexp_lane*RW +: RW] = 16'hdead;
      unexp_lane = -1;
    end
    if (rst) begin
      in_valid       = 1'b0;
      lane_res_valid = '0;
    end else begin
      in_valid = (src_q.size() > 0) || ($urandom_range(0, 99) < in_rate);
    end
    in_fea    = (src_q.size() > 0) ? src_q[0] : rand_fea();
    out_ready = ($urandom_range(0, 99) < or_pct);
  endtask

  // Predict the effect of the coming clock edge from the inputs just driven.
  task automatic model_edge();
    logic [N-1:0] elig, cap;
    logic drn;
    int g, h, idx;
    elig = lane_req & ~m_infl & ~m_full;
    m_in_ready = |elig;
    drn = (m_order.size() > 0) && m_full[m_order[0]] && out_ready;
    cap = lane_res_valid & m_infl;
    if (|(lane_res_valid & ~m_infl)) m_err = 1'b1;
    m_infl  = m_infl & ~cap;
    m_full  = m_full | cap;
    m_pulse = '0;
    if (in_valid && m_in_ready) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && elig[idx]) g = idx;
      end
      m_pulse[g] = 1'b1;
      m_infl[g]  = 1'b1;
      m_fea      = in_fea;
      m_order.push_back(g);
      exp_q.push_back('{res_of(in_fea, g), g});
      m_rr = (g + 1) % N;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (drn) begin
      h = m_order.pop_front();
      m_full[h] = 1'b0;
    end
  endtask

  task automatic post_edge_checks();
    check("lane_fea_valid", lane_fea_valid, m_pulse);
    check("lane_fea", lane_fea, m_fea);
    check("busy_lanes", busy_lanes, popc(m_infl | m_full));
    check("out_valid", out_valid, (m_order.size() > 0) && m_full[m_order[0]]);
    check("err_unexp", err_unexp, m_err);
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      post_edge_checks();
      pulse_seen = pulse_seen | lane_fea_valid;
      for (int i = 0; i < N; i++) begin
        if (lane_fea_valid[i]) begin
          lfea[i] = lane_fea;
          hold[i] = $urandom_range(0, 2);
          cnt[i]  = $urandom_range(lat_min[i], lat_max[i]);
          st[i]   = 1;
        end
      end
    end
    #2;
    drive_inputs();
    if (!rst) model_edge();
    #1;
    if (!rst) check("in_ready", in_ready, m_in_ready);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_lane_fea_valid", lane_fea_valid, 0);
    check("rst_lane_fea", lane_fea, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_busy_lanes", busy_lanes, 0);
    check("rst_err_unexp", err_unexp, 0);
    model_clear();
    repeat (2) step();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pops one expected result per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst === 1'b0 && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_spurious: got data %0h lane %0d expected no output", out_data, out_lane);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.res);
          check("out_lane", out_lane, e.lane);
        end
      end
    end
  end

  initial begin
    model_clear();
    set_lat(1, 8);

    // Basic: three consecutive packets land on lanes 0, 1, 2.
    do_reset();
    set_lat(20, 20);
    src_q.push_back(128'hA); src_q.push_back(128'hB); src_q.push_back(128'hC);
    repeat (5) step();
    check("basic_busy3", busy_lanes, 3);
    check("basic_lanes", pulse_seen, 4'b0111);
    repeat (30) step();

    // Reorder: lane1 finishes first but lane0's result leaves first.
    do_reset();
    lat_min[0] = 8; lat_max[0] = 8; lat_min[1] = 3; lat_max[1] = 3;
    src_q.push_back(rand_fea()); src_q.push_back(rand_fea());
    repeat (20) step();
    check("reorder_drained", exp_q.size(), 0);

    // Backpressure: all four results held, then one drain frees lane0.
    do_reset();
    set_lat(2, 2);
    or_pct = 0;
    repeat (4) src_q.push_back(rand_fea());
    repeat (14) step();
    check("bp_in_ready", in_ready, 0);
    check("bp_busy4", busy_lanes, 4);
    or_pct = 100;
    step();
    or_pct = 0;
    src_q.push_back(rand_fea());
    step();
    step();
    check("bp_regrant", lane_fea_valid, 4'b0001);
    or_pct = 100;
    repeat (20) step();

    // Round-robin with gaps: only lanes 1 and 3 request.
    do_reset();
    set_lat(2, 2);
    req_mask = 4'b1010;
    repeat (3) src_q.push_back(rand_fea());
    repeat (25) step();
    check("rr_gap_lanes", pulse_seen, 4'b1010);
    req_mask = '1;

    // Unexpected result pulse on an idle lane sets the sticky error.
    repeat (5) step();
    unexp_lane = 2;
    repeat (3) step();
    check("err_sticky", err_unexp, 1);
    check("err_no_output", out_valid, 0);
    repeat (2) src_q.push_back(rand_fea());
    repeat (20) step();

    // Reset mid-operation: lane0 result held, lanes 1 and 2 inflight.
    do_reset();
    lat_min[0] = 2; lat_max[0] = 2;
    for (int i = 1; i < N; i++) begin
      lat_min[i] = 40; lat_max[i] = 40;
    end
    or_pct = 0;
    repeat (3) src_q.push_back(rand_fea());
    repeat (10) step();
    check("midop_busy3", busy_lanes, 3);
    do_reset();
    set_lat(1, 8);
    or_pct = 100;
    src_q.push_back(rand_fea());
    repeat (3) step();
    check("post_reset_lane0", pulse_seen, 4'b0001);

    // Randomised traffic.
    in_rate = 60; req_pct = 85; or_pct = 70;
    repeat (3000) step();

    // Drain everything still outstanding, with a bounded wait.
    in_rate = 0; or_pct = 100; req_pct = 100;
    for (int t = 0; t < 300 && exp_q.size() > 0; t++) step();
    repeat (3) step();
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vpe_pkt_dispatcher.md
Name: vpe_pkt_dispatcher

Overview:
Shares one incoming packet-feature stream among N_LANE VPE instances. It hands each feature vector to an idle VPE lane in round-robin order and captures that lane's result pulse. It returns results in packet arrival order over a valid/ready output port. It sits between the packet parser and the VPE array, driving each lane's pkt_fea_valid and consuming its fetch_pkt_fea and out_valid.

Parameters:
N_LANE, 4, number of VPE lanes (2..8)
FEA_W, 128, feature vector width
RES_W, 16, per-packet result width
LW, $clog2(N_LANE), lane index width (derived, not overridable)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  feature vector available
in_ready  output  1  dispatcher accepts in_fea this cycle
in_fea  input  FEA_W  feature vector
lane_req  input  N_LANE  per-lane fetch_pkt_fea (level, lane idle)
lane_fea_valid  output  N_LANE  one-hot per-lane pkt_fea_valid pulse
lane_fea  output  FEA_W  registered feature vector, broadcast to all lanes
lane_res_valid  input  N_LANE  per-lane result pulse (VPE out_valid)
lane_res  input  N_LANE*RES_W  per-lane result, lane i at [i*RES_W +: RES_W]
out_valid  output  1  in-order result available
out_ready  input  1  downstream accepts result
out_data  output  RES_W  result
out_lane  output  LW  lane that produced out_data
busy_lanes  output  LW+1  count of lanes inflight or holding an unread result
err_unexp  output  1  sticky: result pulse from a lane with nothing inflight

Behaviour:
- Reset values: in_ready=0, lane_fea_valid=0, lane_fea=0, out_valid=0, out_data=0, out_lane=0, busy_lanes=0, err_unexp=0. Internal state cleared: inflight=0, slot_full=0, order FIFO empty, rr_ptr=0.
- Reset mid-operation discards all inflight packets and held results. Lanes share the same rst.
- Lane eligibility: elig[i] = lane_req[i] & ~inflight[i] & ~slot_full[i].
- in_ready is combinational: |elig. Accept fires when in_valid & in_ready.
- Grant g is the first eligible lane at or after rr_ptr, searching upward and wrapping at N_LANE-1 -> 0.
- On accept, at the next edge:
  - lane_fea <= in_fea.
  - lane_fea_valid <= one-hot(g) for exactly one cycle.
  - inflight[g] <= 1.
  - g is pushed to the order FIFO.
  - rr_ptr <= g+1 mod N_LANE.
- Without accept, lane_fea_valid <= 0 and lane_fea holds its value.
- Dispatch latency is 1 cycle from accept to the lane pulse.
- lane_req may remain high for 1-2 cycles after the grant. inflight blocks a double grant.
- Result capture, at the edge where lane_res_valid[i]=1 and inflight[i]=1:
  - slot[i] <= lane_res[i].
  - slot_full[i] <= 1.
  - inflight[i] <= 0.
  - If inflight[i]=0 instead, the pulse is ignored and err_unexp <= 1 (sticky until reset).
- Multiple lanes may pulse in the same cycle; all are captured.
- Order FIFO:
  - Depth N_LANE, entries LW bits.
  - Cannot overflow: each lane owns at most one entry.
  - Push and pop in the same cycle are allowed.
- Output: h = FIFO head. out_valid = ~empty & slot_full[h], out_data = slot[h], out_lane = h (registered state, no combinational path from inputs).
- On out_valid & out_ready: pop FIFO, slot_full[h] <= 0. Lane h becomes eligible the following cycle.
- Results from later packets are held until the head lane's result is drained. This applies backpressure by blocking re-dispatch to those lanes.
- A capture and a drain of the same lane in one cycle cannot occur, because inflight and slot_full are mutually exclusive. Capture on one lane and drain on another in the same cycle is allowed.
- busy_lanes = popcount(inflight | slot_full), updated each cycle.
- One result per dispatched packet. The lane program must issue OUT exactly once before FIN.

Decomposition:
- Shared package vpe_pkg: RES_W and FEA_W defaults, plus a lane-index typedef sized for the largest N_LANE, so VPE-array top and dispatcher agree.
- One sub-module is natural: vpe_order_fifo (parameterised depth/width sync FIFO with push/pop/empty/full and head output), reusable elsewhere in the array.
- The round-robin search stays inline.

Test Plan:
- Basic, N_LANE=4, all lane_req=1: send fea 0xA, 0xB, 0xC on consecutive cycles -> lane_fea_valid = 0001, 0010, 0100, each one cycle after accept; lane_fea matches; busy_lanes reaches 3.
- Reorder: dispatch P0->lane0, P1->lane1; lane1 returns 0x0011 at t=10, lane0 returns 0x0022 at t=15 -> out_valid stays 0 until t=16, then output is 0x0022/lane0, then 0x0011/lane1.
- Backpressure: out_ready=0, 4 packets dispatched and all results returned -> in_ready=0 and busy_lanes=4. Raise out_ready for one cycle -> lane0 slot drains, and the next cycle in_ready=1 and a new packet grants lane0.
- Round-robin with gaps: lane_req=1010, rr_ptr=0 -> grants lane1, then lane3, then lane1; lanes 0 and 2 are never pulsed.
- Error: lane_res_valid[2] pulses with nothing inflight on lane 2 -> err_unexp=1 and stays 1; no output produced; subsequent traffic is unaffected.
- Reset mid-operation: assert rst with 2 lanes inflight and 1 result held -> all outputs return to 0 asynchronously. After release, the first packet grants lane0.
